// File: rtl/stack_rpn_pkg.sv
// rtl/stack_rpn_pkg.sv - opcodes, FSM states and per-op stack requirements for the RPN stack master
package stack_rpn_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_XOR  = 3'd5,
        OP_DUP  = 3'd6,
        OP_SWAP = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR   = 3'd3,
        ST_WR2  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // grows: the op leaves the stack one entry deeper, so it needs a free slot
    typedef struct packed {
        logic [1:0] min_cnt;
        logic       grows;
    } op_req_t;

    function automatic op_req_t op_req(op_e op);
        op_req_t r;
        case (op)
            OP_PUSH: r = '{min_cnt: 2'd0, grows: 1'b1};
            OP_POP:  r = '{min_cnt: 2'd1, grows: 1'b0};
            OP_DUP:  r = '{min_cnt: 2'd1, grows: 1'b1};
            default: r = '{min_cnt: 2'd2, grows: 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// rtl/rpn_alu.sv - combinational value to push for each op; A is the former top, B the entry below
module rpn_alu
    import stack_rpn_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] arg_i,
    output logic [WIDTH-1:0] val_o
);

    always_comb begin
        val_o = '0;
        case (op_e'(op_i))
            OP_PUSH: val_o = arg_i;
            OP_ADD:  val_o = b_i + a_i;
            OP_SUB:  val_o = b_i - a_i;
            OP_AND:  val_o = b_i & a_i;
            OP_XOR:  val_o = b_i ^ a_i;
            OP_DUP:  val_o = a_i;
            OP_SWAP: val_o = a_i;
            default: val_o = '0;
        endcase
    end

endmodule

// File: rtl/stack_rpn_ctrl.sv
// rtl/stack_rpn_ctrl.sv - RPN command master driving a LIFO stack; STACK_RPN_CHECK_EN adds sticky chk_err_o
module stack_rpn_ctrl
    import stack_rpn_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [OP_W-1:0]  cmd_op_i,
    input  logic [WIDTH-1:0] cmd_arg_i,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_err_o,
    output logic             st_push_o,
    output logic             st_pop_o,
    output logic [WIDTH-1:0] st_data_in_o,
    input  logic [WIDTH-1:0] st_data_out_i,
    input  logic             st_full_i,
    input  logic             st_empty_i
`ifdef STACK_RPN_CHECK_EN
    ,
    output logic             chk_err_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] S_IDLE = 3'(ST_IDLE);
    localparam logic [2:0] S_RD_A = 3'(ST_RD_A);
    localparam logic [2:0] S_RD_B = 3'(ST_RD_B);
    localparam logic [2:0] S_WR   = 3'(ST_WR);
    localparam logic [2:0] S_WR2  = 3'(ST_WR2);
    localparam logic [2:0] S_DONE = 3'(ST_DONE);

    logic [2:0]       state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] alu_val;
    op_req_t          req;
    logic             push, pop;

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .arg_i (arg_q),
        .val_o (alu_val)
    );

    // Strobes are pure state decodes; DUP only peeks in RD_A
    assign push         = (state_q == S_WR) || (state_q == S_WR2);
    assign pop          = ((state_q == S_RD_A) && (op_q != OP_DUP)) || (state_q == S_RD_B);
    assign st_push_o    = push;
    assign st_pop_o     = pop;
    assign st_data_in_o = (state_q == S_WR) ? alu_val : ((state_q == S_WR2) ? b_q : '0);
    assign cmd_ready_o  = (state_q == S_IDLE);
    assign res_valid_o  = (state_q == S_DONE);
    assign res_err_o    = (state_q == S_DONE) && err_q;
    assign res_data_o   = (state_q == S_DONE) ? res_q : '0;

    assign req = op_req(op_e'(cmd_op_i));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d  = op_e'(cmd_op_i);
                    arg_d = cmd_arg_i;
                    res_d = '0;
                    err_d = (cnt_q < CNT_W'(req.min_cnt)) ||
                            (req.grows && (cnt_q == CNT_W'(DEPTH)));
                    if (err_d)
                        state_d = S_DONE;
                    else if (op_e'(cmd_op_i) == OP_PUSH)
                        state_d = S_WR;
                    else
                        state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                a_d = st_data_out_i;
                if (op_q == OP_POP) begin
                    res_d   = st_data_out_i;
                    state_d = S_DONE;
                end else if (op_q == OP_DUP) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_RD_B;
                end
            end
            S_RD_B: begin
                b_d     = st_data_out_i;
                state_d = S_WR;
            end
            S_WR: begin
                res_d   = alu_val;
                state_d = (op_q == OP_SWAP) ? S_WR2 : S_DONE;
            end
            S_WR2: begin
                res_d   = b_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push)
            cnt_d = cnt_q + CNT_W'(1);
        else if (pop)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_PUSH;
            arg_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STACK_RPN_CHECK_EN
    logic chk_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            chk_q <= 1'b0;
        else if ((state_q == S_IDLE) &&
                 (((cnt_q == '0) != st_empty_i) || ((cnt_q == CNT_W'(DEPTH)) != st_full_i)))
            chk_q <= 1'b1;
    end

    assign chk_err_o = chk_q;
`else
    logic unused_flags;
    assign unused_flags = st_full_i ^ st_empty_i;
`endif

endmodule

// File: tb/tb_stack_rpn_ctrl.sv
// tb/tb_stack_rpn_ctrl.sv - directed vector table, reset abort and random op stream against a queue model
module tb_stack_rpn_ctrl;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [1:0] cmd_arg = 2'd0;
    logic       res_valid;
    logic [1:0] res_data;
    logic       res_err;
    logic       st_push, st_pop;
    logic [1:0] st_data_in;
    logic [1:0] st_data_out;
    logic       st_full, st_empty;
`ifdef STACK_RPN_CHECK_EN
    logic       chk_err;
`endif

    always #5 clk = ~clk;

    stack_rpn_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (cmd_op),
        .cmd_arg_i     (cmd_arg),
        .res_valid_o   (res_valid),
        .res_data_o    (res_data),
        .res_err_o     (res_err),
        .st_push_o     (st_push),
        .st_pop_o      (st_pop),
        .st_data_in_o  (st_data_in),
        .st_data_out_i (st_data_out),
        .st_full_i     (st_full),
        .st_empty_i    (st_empty)
`ifdef STACK_RPN_CHECK_EN
        ,
        .chk_err_o     (chk_err)
`endif
    );

    // Behavioural LIFO standing in for the stack instance
    logic [1:0] mem [0:3];
    logic [2:0] sp = 3'd0;

    always @(posedge clk) begin
        if (rst)
            sp <= 3'd0;
        else if (st_push && sp < 3'd4) begin
            mem[sp[1:0]] <= st_data_in;
            sp <= sp + 3'd1;
        end else if (st_pop && sp != 3'd0)
            sp <= sp - 3'd1;
    end

    always_comb begin
        st_data_out = 2'd0;
        if (sp != 3'd0)
            st_data_out = mem[2'(sp - 3'd1)];
    end
    assign st_full  = (sp == 3'd4);
    assign st_empty = (sp == 3'd0);

    int tests = 0;
    int fails = 0;
    int issued = 0;
    int accepts = 0;
    int overlap = 0;

    always @(posedge clk)
        if (!rst && cmd_valid && cmd_ready)
            accepts++;

    always @(negedge clk)
        if (st_push && st_pop)
            overlap++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_cmd(input int op, input int arg, input bit hold,
                          output int data, output int err, output int lat,
                          output int np, output int npo);
        int budget;
        @(negedge clk);
        budget = 0;
        while (!cmd_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_arg   = 2'(arg);
        issued++;
        @(negedge clk);
        if (!hold)
            cmd_valid = 1'b0;
        data = 0; err = 0; np = 0; npo = 0;
        lat = 1;
        while (1) begin
            np  += int'(st_push);
            npo += int'(st_pop);
            if (res_valid) begin
                data = int'(res_data);
                err  = int'(res_err);
                break;
            end
            if (lat >= 20) begin
                lat = 99;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    // Reference: stack as a queue, results from the op definitions directly
    logic [1:0] rq[$];

    task automatic model(input int op, input int arg, output int data, output int err,
                         output int lat, output int np, output int npo);
        int need, a, b, r;
        bit grows;
        need  = (op == 0) ? 0 : ((op == 1 || op == 6) ? 1 : 2);
        grows = (op == 0 || op == 6);
        data = 0; err = 0;
        if (rq.size() < need || (grows && rq.size() == DEPTH)) begin
            err = 1; lat = 1; np = 0; npo = 0;
            return;
        end
        case (op)
            0: begin rq.push_back(2'(arg)); data = arg; lat = 2; np = 1; npo = 0; end
            1: begin data = int'(rq.pop_back()); lat = 2; np = 0; npo = 1; end
            6: begin data = int'(rq[$]); rq.push_back(2'(data)); lat = 3; np = 1; npo = 0; end
            7: begin
                a = int'(rq.pop_back()); b = int'(rq.pop_back());
                rq.push_back(2'(a)); rq.push_back(2'(b));
                data = b; lat = 5; np = 2; npo = 2;
            end
            default: begin
                a = int'(rq.pop_back()); b = int'(rq.pop_back());
                case (op)
                    2: r = (b + a) % 4;
                    3: r = (b - a + 4) % 4;
                    4: r = b & a;
                    default: r = b ^ a;
                endcase
                rq.push_back(2'(r));
                data = r; lat = 4; np = 1; npo = 2;
            end
        endcase
    endtask

    typedef struct {
        int op; int arg; int data; int err; int lat; int np; int npo;
    } vec_t;

    vec_t tbl [28] = '{
        '{0,3,3,0,2,1,0}, '{1,0,3,0,2,0,1},
        '{0,1,1,0,2,1,0}, '{0,3,3,0,2,1,0}, '{2,0,0,0,4,1,2}, '{1,0,0,0,2,0,1},
        '{1,0,0,1,1,0,0},
        '{0,1,1,0,2,1,0}, '{0,2,2,0,2,1,0}, '{3,0,3,0,4,1,2}, '{1,0,3,0,2,0,1},
        '{0,2,2,0,2,1,0}, '{0,1,1,0,2,1,0}, '{7,0,2,0,5,2,2}, '{1,0,2,0,2,0,1},
        '{1,0,1,0,2,0,1},
        '{2,0,0,1,1,0,0}, '{0,1,1,0,2,1,0}, '{2,0,0,1,1,0,0}, '{6,0,1,0,3,1,0},
        '{0,2,2,0,2,1,0}, '{0,3,3,0,2,1,0}, '{0,0,0,1,1,0,0}, '{6,0,0,1,1,0,0},
        '{4,0,2,0,4,1,2}, '{5,0,3,0,4,1,2}, '{1,0,3,0,2,0,1}, '{1,0,1,0,2,0,1}
    };

    initial begin
        int d, e, l, p, q;
        int md, me, ml, mp, mq;
        int op;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_res_err", int'(res_err), 0);
        check("rst_strobes", int'({st_push, st_pop}), 0);
        check("rst_data_in", int'(st_data_in), 0);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            do_cmd(tbl[i].op, tbl[i].arg, 1'b0, d, e, l, p, q);
            check($sformatf("vec%0d_data", i), d, tbl[i].data);
            check($sformatf("vec%0d_err", i), e, tbl[i].err);
            check($sformatf("vec%0d_lat", i), l, tbl[i].lat);
            check($sformatf("vec%0d_push", i), p, tbl[i].np);
            check($sformatf("vec%0d_pop", i), q, tbl[i].npo);
            if (i == 5)
                check("empty_after_pop", int'(st_empty), 1);
        end
        check("table_end_depth", int'(sp), 0);

        // Reset while an XOR sits in RD_B
        do_cmd(0, 1, 1'b0, d, e, l, p, q);
        do_cmd(0, 2, 1'b0, d, e, l, p, q);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd5; issued++;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("xor_rdb_pop", int'(st_pop), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_strobes", int'({st_push, st_pop}), 0);
        check("abort_res_valid", int'(res_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_strobes", int'({st_push, st_pop}), 0);
        do_cmd(1, 0, 1'b0, d, e, l, p, q);
        check("abort_pop_err", e, 1);
        check("abort_pop_nostrobe", p + q, 0);

        rq.delete();
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 7));
            if (((op == 1 || op == 6) && rq.size() < 1) || ((op >= 2 && op <= 5 || op == 7) && rq.size() < 2) ||
                ((op == 0 || op == 6) && rq.size() == DEPTH))
                op = (rq.size() < DEPTH) ? 0 : 1;
            d = int'($urandom_range(0, 3));
            model(op, d, md, me, ml, mp, mq);
            do_cmd(op, d, 1'b1, d, e, l, p, q);
            tests++;
            if (d != md || e != me || l != ml || p != mp || q != mq) begin
                fails++;
                $display("FAIL rand%0d op%0d: got data %0d err %0d lat %0d push %0d pop %0d expected %0d %0d %0d %0d %0d",
                         i, op, d, e, l, p, q, md, me, ml, mp, mq);
            end
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("accepts_vs_issued", accepts, issued);
        check("push_pop_overlap", overlap, 0);
        check("final_depth", int'(sp), rq.size());
`ifdef STACK_RPN_CHECK_EN
        check("chk_err", int'(chk_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
